// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus interface.
// Bundles the receiver interrupt handshake (enable_data_interrupt, data, disable_data_interrupt)
// and the OS-side read port (read_nic, clr_overflow, data_out, read_nic_i, count, overflow).
//   master : receiver + OS side (drives the handshake request and read strobes)
//   slave  : the FIFO itself
interface uart_rx_fifo_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADDR_W    = 4
);
  logic                 enable_data_interrupt;
  logic [WORD_SIZE-1:0] data;
  logic                 disable_data_interrupt;
  logic                 read_nic;
  logic                 clr_overflow;
  logic [WORD_SIZE-1:0] data_out;
  logic                 read_nic_i;
  logic [ADDR_W:0]      count;
  logic                 overflow;

  modport master (
    output enable_data_interrupt, data, read_nic, clr_overflow,
    input  disable_data_interrupt, data_out, read_nic_i, count, overflow
  );

  modport slave (
    input  enable_data_interrupt, data, read_nic, clr_overflow,
    output disable_data_interrupt, data_out, read_nic_i, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver and the host controller.
// Captures one byte per receiver interrupt assertion, acknowledges it, and queues it in a
// circular FIFO that the OS drains with a read strobe.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset
//   bus_io : uart_rx_fifo_if.slave (handshake in/ack out, read strobe, data_out, status)
module uart_rx_fifo #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus_io
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {StWaitIrq, StAck} state_e;

  state_e                 state_q;
  logic                   ack_q;
  logic [WORD_SIZE-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic [WORD_SIZE-1:0]   data_out_q, data_out_d;
  logic                   overflow_q, overflow_d;

  logic push_req, push_ok, pop_ok;

  // Only the capture edge in WaitIrq pushes, so a long-held interrupt yields one byte.
  assign push_req = (state_q == StWaitIrq) && bus_io.enable_data_interrupt;
  // Pop needs a stored byte; no bypass from a same-cycle push into an empty FIFO.
  assign pop_ok   = bus_io.read_nic && (count_q != '0);
  // A full FIFO still accepts the push when a pop frees a slot on the same edge.
  assign push_ok  = push_req && ((count_q < DepthCnt) || pop_ok);

  // Handshake FSM with registered acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StWaitIrq;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        StWaitIrq: begin
          if (bus_io.enable_data_interrupt) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
          end
        end
        StAck: begin
          if (!bus_io.enable_data_interrupt) begin
            state_q <= StWaitIrq;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StWaitIrq;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    // A dropped byte wins over a simultaneous clear.
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end else if (bus_io.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are only observable after a push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus_io.data;
    end
  end

  assign bus_io.disable_data_interrupt = ack_q;
  assign bus_io.data_out               = data_out_q;
  assign bus_io.count                  = count_q;
  assign bus_io.read_nic_i             = (count_q != '0);
  assign bus_io.overflow               = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed test-plan steps followed by a randomized receiver/OS
// phase, every cycle checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int unsigned WordSize = 8;
  localparam int unsigned Depth    = 16;
  localparam int unsigned AddrW    = 4;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_ack;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.WORD_SIZE(WordSize), .ADDR_W(AddrW)) bus ();

  uart_rx_fifo #(
    .WORD_SIZE(WordSize),
    .DEPTH    (Depth),
    .ADDR_W   (AddrW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},    32'(bus.count),                  32'(mq.size()));
    check({tag, ".avail"},    32'(bus.read_nic_i),             32'(mq.size() != 0));
    check({tag, ".data_out"}, 32'(bus.data_out),               32'(m_dout));
    check({tag, ".overflow"}, 32'(bus.overflow),               32'(m_ovf));
    check({tag, ".ack"},      32'(bus.disable_data_interrupt), 32'(m_ack));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_ack  = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the behavioural rules, then compare.
  task automatic step(input bit en, input logic [7:0] d, input bit rd, input bit clr,
                      input string tag);
    bit pop_ok, push_try, push_ok;
    bus.enable_data_interrupt = en;
    bus.data                  = d;
    bus.read_nic              = rd;
    bus.clr_overflow          = clr;
    pop_ok   = rd && (mq.size() != 0);
    push_try = en && !m_ack;
    push_ok  = push_try && ((mq.size() < Depth) || pop_ok);
    if (pop_ok)  m_dout = mq.pop_front();
    if (push_ok) mq.push_back(d);
    if (push_try && !push_ok) m_ovf = 1'b1;
    else if (clr)             m_ovf = 1'b0;
    if (push_try)  m_ack = 1'b1;
    else if (!en)  m_ack = 1'b0;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic handshake(input logic [7:0] d, input int hold, input string tag);
    for (int i = 0; i < hold; i++) step(1'b1, d, 1'b0, 1'b0, tag);
    step(1'b0, d, 1'b0, 1'b0, tag);
  endtask

  task automatic pops(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         en_r;
    logic [7:0] d_r;

    rst                       = 1'b0;
    bus.enable_data_interrupt = 1'b0;
    bus.data                  = '0;
    bus.read_nic              = 1'b0;
    bus.clr_overflow          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare_all("post_reset");

    // Single byte, interrupt held 5 cycles, then one read strobe
    handshake(8'h55, 5, "single");
    check("single.byte_present", 32'(bus.count), 32'd1);
    pops(1, "single_rd");
    check("single.data_out", 32'(bus.data_out), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0, "single_idle");

    // Fill and overflow with 0x00..0x10
    for (int i = 0; i <= 16; i++) handshake(8'(i), 2, "fill");
    check("fill.full",     32'(bus.count),    32'd16);
    check("fill.overflow", 32'(bus.overflow), 32'd1);

    // Clear coincident with a rejected push: set wins
    step(1'b1, 8'h11, 1'b0, 1'b1, "clr_vs_set");
    step(1'b0, 8'h11, 1'b0, 1'b0, "clr_vs_set");
    // Clear alone
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
    check("clr_alone.overflow", 32'(bus.overflow), 32'd0);

    // Full FIFO, push and pop on the same edge
    step(1'b1, 8'h22, 1'b1, 1'b0, "full_simul");
    check("full_simul.count", 32'(bus.count), 32'd16);
    step(1'b0, 8'h22, 1'b0, 1'b0, "full_simul");
    pops(16, "drain");
    check("drain.last", 32'(bus.data_out), 32'h22);

    // Wrap-around
    for (int i = 0; i < 10; i++) handshake(8'(8'h30 + i), 1, "wrap_pre");
    pops(10, "wrap_pre_rd");
    for (int i = 0; i < 12; i++) handshake(8'(8'hA0 + i), 1, "wrap");
    for (int i = 0; i < 12; i++) begin
      pops(1, "wrap_rd");
      check("wrap.order", 32'(bus.data_out), 32'(8'hA0 + i));
    end

    // Empty FIFO, push and pop on the same edge: no bypass
    step(1'b1, 8'h77, 1'b1, 1'b0, "empty_simul");
    check("empty_simul.data_out", 32'(bus.data_out), 32'hAB);
    step(1'b0, 8'h77, 1'b0, 1'b0, "empty_simul");
    pops(1, "empty_simul_rd");

    // Randomized receiver and OS traffic
    en_r = 1'b0;
    d_r  = '0;
    for (int i = 0; i < 600; i++) begin
      if (!en_r) begin
        if ($urandom_range(0, 2) == 0) begin
          en_r = 1'b1;
          d_r  = 8'($urandom);
        end
      end else if ($urandom_range(0, 1) == 0) begin
        en_r = 1'b0;
      end
      step(en_r, d_r, (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 9) == 0), "rand");
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, "rand_end");
    pops(Depth + 1, "rand_drain");

    // Asynchronous reset while acknowledging with three bytes stored
    handshake(8'hC1, 1, "pre_rst");
    handshake(8'hC2, 1, "pre_rst");
    step(1'b1, 8'hC3, 1'b0, 1'b0, "pre_rst");
    check("pre_rst.count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    bus.enable_data_interrupt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare_all("rst_release");
    pops(3, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between UART_RECEIVER and the UART_CONTROLLER host interface.
- Consumes the receiver's interrupt handshake, which uses enable_data_interrupt and data, and acknowledges it with disable_data_interrupt.
- Stores bytes in a circular FIFO.
- Presents bytes to the OS side through a read_nic strobe, data_out, and a read_nic_i "data available" flag.
- Lets the controller absorb back-to-back frames without losing bytes while the OS is slow.

Parameters:
WORD_SIZE, 8, width of one received byte.
DEPTH, 16, FIFO entries; must be a power of two, at least 2.
ADDR_W, 4, pointer width, log2(DEPTH).

Ports:
clk  in  1  system clock (50 MHz); all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
enable_data_interrupt  in  1  from receiver: a valid byte is on data; held high until acknowledged.
data  in  WORD_SIZE  from receiver: received byte; stable while enable_data_interrupt is high.
disable_data_interrupt  out  1  to receiver: acknowledge; high while the FSM is in ACK.
read_nic  in  1  OS read strobe; one pop per cycle in which it is high.
clr_overflow  in  1  clears the sticky overflow flag.
data_out  out  WORD_SIZE  last popped byte (registered).
read_nic_i  out  1  FIFO non-empty (count != 0).
count  out  ADDR_W+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr and count = 0; data_out = 0; overflow = 0.
  - disable_data_interrupt = 0; FSM = WAIT_IRQ.
  - Memory contents are don't-care.
- FSM, two states:
  - WAIT_IRQ:
    - On a clock edge with enable_data_interrupt=1, attempt a push of data, then go to ACK.
    - Otherwise stay.
  - ACK:
    - disable_data_interrupt=1 as a registered output, so it asserts the cycle after capture.
    - Stay while enable_data_interrupt=1.
    - When enable_data_interrupt=0, go to WAIT_IRQ; disable_data_interrupt drops on that edge.
  - Exactly one push per interrupt assertion, regardless of how long enable_data_interrupt is held.
- Push:
  - Accepted if count < DEPTH, or if a pop is accepted in the same cycle.
  - Accepted push: mem[wr_ptr] <= data; wr_ptr wraps modulo DEPTH.
  - Rejected push: byte dropped, overflow <= 1; the handshake still completes through ACK.
- Pop:
  - Accepted on a clock edge with read_nic=1 and count != 0.
  - Effect: data_out <= mem[rd_ptr]; rd_ptr wraps modulo DEPTH. Latency is 1 cycle from the strobe edge to data_out.
  - read_nic with count=0 is ignored: data_out holds, no flag is raised.
  - A read_nic held high for N cycles pops up to N bytes.
- Count:
  - +1 on push only; -1 on pop only; unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- Simultaneous push and pop:
  - Empty: no bypass; the pop is ignored and count becomes 1.
  - Full: both are accepted; count stays DEPTH and no overflow is raised.
- overflow:
  - Set by a rejected push; cleared by clr_overflow=1.
  - Set has priority over clear in the same cycle.
- read_nic_i is combinational from count (count != 0) and glitch-free relative to clk.
- Pointer wrap: after DEPTH pushes and DEPTH pops, the pointers return to 0. FIFO order is preserved across the wrap.
- Reset mid-handshake:
  - FSM returns to WAIT_IRQ and disable_data_interrupt drops immediately.
  - A still-high enable_data_interrupt after reset release is treated as a new byte. The receiver shares rst, so this does not occur in the system.

Test Plan:
- Single byte:
  - Stimulus: receiver handshake with data=0x55 held high for 5 cycles, then read_nic pulsed 1 cycle.
  - Response: disable_data_interrupt high from the cycle after capture until one edge after the interrupt falls; count 0->1; read_nic_i=1; data_out=0x55 one cycle after the strobe; count=0; read_nic_i=0.
- Fill and overflow:
  - Stimulus: 17 handshakes with bytes 0x00..0x10, no reads.
  - Response: count=16; overflow=1 after the 17th; the 17th handshake still acknowledged.
  - Then 16 reads return 0x00..0x0F in order; count=0.
- Wrap-around:
  - Stimulus: 10 pushes and 10 pops, then 12 pushes (0xA0..0xAB) and 12 pops.
  - Response: exactly 0xA0..0xAB in order; no overflow.
- Simultaneous events:
  - Full FIFO, handshake and read_nic on the same edge: count stays 16, overflow stays 0.
  - Empty FIFO, same: count becomes 1, data_out unchanged.
- Clear versus set:
  - overflow=1 with clr_overflow pulsed alone: overflow goes to 0.
  - clr_overflow coincident with a rejected push: overflow stays 1.
- Reset:
  - Stimulus: rst low asynchronously while in ACK with count=3.
  - Response: immediately count=0, read_nic_i=0, disable_data_interrupt=0, data_out=0.
  - After release, read_nic pulses are ignored.
